wave_gen_multi: RTL and testbench
=================================

Name: wave_gen_multi

Overview:
- Multi-channel, parametrised successor to the single-channel on/off square-wave generator.
- Each channel outputs a programmable waveform: high for M time units, then low for N time units. One time unit is TICK_DIV clock cycles.
- New over the previous generation:
  - configurable widths and channel count;
  - shadow registers, so updates take effect glitch-free at period boundaries;
  - per-channel one-shot mode with trigger;
  - graceful stop on enable deassert;
  - end-of-period pulse.
- Sits between the control/register logic and output pins or LEDs.

Parameters:
- N_CH, 2, number of independent channels.
- WIDTH, 4, bit width of the M (on) and N (off) counts.
- TICK_DIV, 5, clocks per time unit; must be ≥1. Prescaler width is derived with $clog2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  N_CH  per-channel enable (level).
- load  in  N_CH  per-channel one-clock strobe; captures m_in/n_in/oneshot into that channel's shadow.
- m_in  in  N_CH*WIDTH  on-time in ticks; channel k uses bits [k*WIDTH +: WIDTH].
- n_in  in  N_CH*WIDTH  off-time in ticks; same slicing.
- oneshot  in  N_CH  mode captured on load; 0 = continuous, 1 = one-shot.
- trigger  in  N_CH  one-clock pulse that starts one period in one-shot mode.
- wave  out  N_CH  registered waveform output.
- busy  out  N_CH  high while the channel is not IDLE.
- period_done  out  N_CH  one-clock pulse at the end of each period.

Behaviour:
- Clocking: one clock. Asynchronous, active-high reset. All outputs are registered.
- Reset values: prescaler, shadow and active M/N/mode, counters and pending flags all 0. State = IDLE. wave = busy = period_done = 0.
- Prescaler:
  - free-running, counts 0..TICK_DIV-1 and wraps;
  - tick = (prescaler == TICK_DIV-1), shared by all channels;
  - TICK_DIV = 1 gives tick every clock;
  - the first tick after reset release is on the TICK_DIV-th rising edge.
- Shadow: load[k] writes the shadow M/N/mode on that edge, whether or not the channel is running. Active values change only at period start.
- Pending trigger:
  - trigger[k] sets pend[k] only when the channel is IDLE and the shadow mode is one-shot;
  - otherwise the trigger is ignored;
  - pend clears at period start.
- State machine (per channel): IDLE, HIGH, LOW. Transitions occur only on edges where tick = 1; the counter counts ticks within a phase.
- Period start (from IDLE, or from a period end in continuous mode):
  - copy shadow to active;
  - cnt = 0;
  - if M = 0 and N = 0: go to IDLE (no period, no pulse);
  - else if M = 0: go to LOW;
  - else: go to HIGH.
- IDLE:
  - start a period on tick if (continuous and en) or pend;
  - wave = 0.
- HIGH:
  - wave = 1;
  - on tick, if cnt == M-1: end phase;
  - else cnt + 1.
  - End phase: if N = 0, period end; else go to LOW with cnt = 0.
- LOW:
  - wave = 0;
  - on tick, if cnt == N-1: period end;
  - else cnt + 1.
- Period end:
  - period_done = 1 for exactly one clock (the edge after the final tick);
  - if continuous and en: immediate period start on the same edge, with no gap cycle;
  - otherwise (one-shot, or en = 0): go to IDLE.
- Resulting period and duty:
  - period = M + N ticks = (M+N)*TICK_DIV clocks;
  - high for M*TICK_DIV clocks.
- Width rules: counters are WIDTH bits. M and N may be up to 2^WIDTH-1, with no overflow.
- Boundary cases:
  - N = 0 and M > 0: wave stays at 1 continuously; period_done pulses every M ticks.
  - M = 0 and N > 0: wave stays at 0; period_done pulses every N ticks.
  - en deasserted mid-period: the current period completes, then IDLE.
  - en reasserted before the period ends: continues seamlessly.
  - load on the same edge as a period start: the start uses the old shadow; the new values apply at the following period.
  - trigger and load on the same edge: trigger is evaluated against the old shadow mode.
  - Channels are fully independent; simultaneous events on different channels do not interact.
  - reset asserted mid-period: immediate return to reset values, and shadow contents are lost.

Test Plan:
- Configuration for all scenarios: N_CH = 2, WIDTH = 4, TICK_DIV = 5.
- Continuous mode, ch0: load M=9, N=4, oneshot=0, en=1 → wave is high 45 clocks then low 20, repeating every 65. period_done pulses at each high restart. ch1 wave stays 0 and busy1 stays 0.
- Reload mid-run: ch0 running 9/4, load M=2, N=2 during the HIGH phase → current period still 45/20; the next period is 10 high / 10 low, with no truncated or glitched pulse.
- One-shot, ch1: load M=3, N=1, oneshot=1, then pulse trigger → exactly one 15-clock high followed by 5 low, period_done once, then IDLE. A second trigger issued while busy produces nothing extra.
- Edge duties, ch0:
  - M=0, N=3 → wave constant 0, period_done every 15 clocks;
  - M=5, N=0 → wave constant 1, period_done every 25 clocks;
  - M=0, N=0 → busy stays 0.
- Enable/reset:
  - drop en 10 clocks into HIGH of a 9/4 period → the period completes (45 high + 20 low), then busy = 0;
  - assert reset mid-HIGH → wave, busy and period_done go to 0 immediately (asynchronously), and the channel stays idle after release until reloaded.

Source files
------------

// File: rtl/wave_gen_multi_if.sv
// Control and output bundle for the multi-channel square-wave generator.
// The controller side takes master; the generator takes slave.
interface wave_gen_multi_if #(
    parameter int N_CH  = 2,
    parameter int WIDTH = 4
);
    logic [N_CH-1:0]       en;
    logic [N_CH-1:0]       load;
    logic [N_CH*WIDTH-1:0] m_in;
    logic [N_CH*WIDTH-1:0] n_in;
    logic [N_CH-1:0]       oneshot;
    logic [N_CH-1:0]       trigger;
    logic [N_CH-1:0]       wave;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       period_done;

    modport master (
        output en, load, m_in, n_in, oneshot, trigger,
        input  wave, busy, period_done
    );

    modport slave (
        input  en, load, m_in, n_in, oneshot, trigger,
        output wave, busy, period_done
    );
endinterface

// File: rtl/wave_gen_multi.sv
// Multi-channel on/off waveform generator: high M ticks, low N ticks per period,
// with shadowed configuration, one-shot triggering and graceful stop.
module wave_gen_multi #(
    parameter int N_CH     = 2,
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 5
) (
    input  logic             clk,
    input  logic             reset,
    wave_gen_multi_if.slave  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    logic [PW-1:0] presc_reg;
    logic          tick;

    assign tick = (presc_reg == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [WIDTH-1:0] sh_m_reg, sh_n_reg, act_m_reg, act_n_reg, cnt_reg;
            logic             sh_os_reg, act_os_reg, pend_reg;
            logic             wave_reg, busy_reg, done_reg;
            state_t           state_reg, start_state;
            logic             last_high, last_low, period_end, do_start;

            // A period starting now always runs from the shadow as it stood before this edge.
            assign start_state = (sh_m_reg != '0) ? HIGH :
                                 (sh_n_reg != '0) ? LOW  : IDLE;

            assign last_high  = (state_reg == HIGH) && (cnt_reg == act_m_reg - WIDTH'(1));
            assign last_low   = (state_reg == LOW)  && (cnt_reg == act_n_reg - WIDTH'(1));
            assign period_end = tick && ((last_high && (act_n_reg == '0)) || last_low);
            assign do_start   = (tick && (state_reg == IDLE) &&
                                 ((!sh_os_reg && bus.en[gi]) || pend_reg)) ||
                                (period_end && !act_os_reg && bus.en[gi]);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sh_m_reg   <= '0;
                    sh_n_reg   <= '0;
                    sh_os_reg  <= 1'b0;
                    act_m_reg  <= '0;
                    act_n_reg  <= '0;
                    act_os_reg <= 1'b0;
                    cnt_reg    <= '0;
                    pend_reg   <= 1'b0;
                    state_reg  <= IDLE;
                    wave_reg   <= 1'b0;
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b0;
                end else begin
                    done_reg <= period_end;

                    if (bus.load[gi]) begin
                        sh_m_reg  <= bus.m_in[gi*WIDTH +: WIDTH];
                        sh_n_reg  <= bus.n_in[gi*WIDTH +: WIDTH];
                        sh_os_reg <= bus.oneshot[gi];
                    end

                    // Trigger is judged against the pre-edge shadow mode.
                    if (bus.trigger[gi] && (state_reg == IDLE) && sh_os_reg) begin
                        pend_reg <= 1'b1;
                    end

                    if (do_start) begin
                        act_m_reg  <= sh_m_reg;
                        act_n_reg  <= sh_n_reg;
                        act_os_reg <= sh_os_reg;
                        cnt_reg    <= '0;
                        pend_reg   <= 1'b0;
                        state_reg  <= start_state;
                        wave_reg   <= (start_state == HIGH);
                        busy_reg   <= (start_state != IDLE);
                    end else if (period_end) begin
                        state_reg <= IDLE;
                        wave_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else if (tick) begin
                        case (state_reg)
                            HIGH: begin
                                if (last_high) begin
                                    state_reg <= LOW;
                                    cnt_reg   <= '0;
                                    wave_reg  <= 1'b0;
                                end else begin
                                    cnt_reg <= cnt_reg + WIDTH'(1);
                                end
                            end
                            LOW: begin
                                cnt_reg <= cnt_reg + WIDTH'(1);
                            end
                            default: begin
                                state_reg <= IDLE;
                            end
                        endcase
                    end
                end
            end

            assign bus.wave[gi]        = wave_reg;
            assign bus.busy[gi]        = busy_reg;
            assign bus.period_done[gi] = done_reg;
        end
    endgenerate
endmodule

// File: tb/tb_wave_gen_multi.sv
// Bench for wave_gen_multi: directed scenarios plus random traffic, checked every
// clock against a tick-position model of each channel.
module tb_wave_gen_multi;
    localparam int N_CH  = 2;
    localparam int WIDTH = 4;
    localparam int TD    = 5;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    wave_gen_multi_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

    wave_gen_multi #(.N_CH(N_CH), .WIDTH(WIDTH), .TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a running channel is a position (in ticks) inside an M+N period.
    int   cyc;
    int   pos [N_CH];
    bit   run [N_CH];
    int   am [N_CH], an [N_CH], sm [N_CH], sn [N_CH];
    bit   aos [N_CH], sos [N_CH], pend [N_CH];
    logic [N_CH-1:0] exp_wave, exp_busy, exp_done;

    int st_hi [N_CH], st_busy [N_CH], st_done [N_CH];

    task automatic model_clear();
        cyc = 0;
        for (int k = 0; k < N_CH; k++) begin
            pos[k] = 0; run[k] = 0; am[k] = 0; an[k] = 0; aos[k] = 0;
            sm[k] = 0;  sn[k] = 0;  sos[k] = 0; pend[k] = 0;
        end
        exp_wave = '0; exp_busy = '0; exp_done = '0;
    endtask

    task automatic model_step();
        bit tk, st, fin, np;
        if (reset) begin
            model_clear();
            return;
        end
        tk = ((cyc % TD) == TD - 1);
        cyc++;
        for (int k = 0; k < N_CH; k++) begin
            st  = 0;
            fin = 0;
            np  = pend[k] | (bus.trigger[k] && !run[k] && sos[k]);
            if (tk) begin
                if (!run[k]) begin
                    st = (!sos[k] && bus.en[k]) || pend[k];
                end else begin
                    pos[k]++;
                    if (pos[k] == am[k] + an[k]) begin
                        fin = 1;
                        st  = !aos[k] && bus.en[k];
                        if (!st) run[k] = 0;
                    end
                end
            end
            if (st) begin
                am[k] = sm[k]; an[k] = sn[k]; aos[k] = sos[k];
                pos[k] = 0;
                run[k] = (am[k] + an[k]) != 0;
                np = 0;
            end
            pend[k] = np;
            if (bus.load[k]) begin
                sm[k]  = int'(bus.m_in[k*WIDTH +: WIDTH]);
                sn[k]  = int'(bus.n_in[k*WIDTH +: WIDTH]);
                sos[k] = bus.oneshot[k];
            end
            exp_wave[k] = run[k] && (pos[k] < am[k]);
            exp_busy[k] = run[k];
            exp_done[k] = fin;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            model_step();
            check("wave", 32'(bus.wave), 32'(exp_wave));
            check("busy", 32'(bus.busy), 32'(exp_busy));
            check("period_done", 32'(bus.period_done), 32'(exp_done));
            for (int k = 0; k < N_CH; k++) begin
                st_hi[k]   += int'(bus.wave[k]);
                st_busy[k] += int'(bus.busy[k]);
                st_done[k] += int'(bus.period_done[k]);
            end
            bus.load    = '0;
            bus.trigger = '0;
        end
    endtask

    task automatic set_cfg(input int ch, input int m, input int n, input bit os);
        bus.m_in[ch*WIDTH +: WIDTH] = WIDTH'(m);
        bus.n_in[ch*WIDTH +: WIDTH] = WIDTH'(n);
        bus.oneshot[ch] = os;
        bus.load[ch]    = 1'b1;
        run_cycles(1);
    endtask

    function automatic logic sig(input int sel, input int ch);
        return (sel == 0) ? bus.wave[ch] : bus.busy[ch];
    endfunction

    task automatic wait_level(input int sel, input int ch, input logic lvl, input string tag);
        int g = 0;
        while (sig(sel, ch) !== lvl && g < 400) begin
            run_cycles(1);
            g++;
        end
        check({tag, "_timeout"}, 32'(g < 400), 32'd1);
    endtask

    task automatic count_level(input int sel, input int ch, input logic lvl, output int n);
        n = 0;
        while (sig(sel, ch) === lvl && n < 400) begin
            run_cycles(1);
            n++;
        end
    endtask

    task automatic measure(input int ch, input int ehi, input int elo, input string tag);
        int n;
        wait_level(0, ch, 1'b0, {tag, "_fall"});
        wait_level(0, ch, 1'b1, {tag, "_rise"});
        count_level(0, ch, 1'b1, n);
        check({tag, "_high_clocks"}, 32'(n), 32'(ehi));
        count_level(0, ch, 1'b0, n);
        check({tag, "_low_clocks"}, 32'(n), 32'(elo));
    endtask

    initial begin
        int n;
        int s_hi [N_CH], s_busy [N_CH], s_done [N_CH];

        for (int k = 0; k < N_CH; k++) begin
            st_hi[k] = 0; st_busy[k] = 0; st_done[k] = 0;
        end
        model_clear();
        reset       = 1'b1;
        bus.en      = '0;
        bus.load    = '0;
        bus.m_in    = '0;
        bus.n_in    = '0;
        bus.oneshot = '0;
        bus.trigger = '0;
        run_cycles(3);
        check("reset_wave", 32'(bus.wave), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.period_done), 32'd0);
        reset = 1'b0;
        run_cycles(2);

        // Continuous 9/4 on ch0; ch1 must stay quiet.
        s_busy = st_busy;
        bus.en[0] = 1'b1;
        set_cfg(0, 9, 4, 1'b0);
        measure(0, 45, 20, "cont");
        s_done = st_done;
        run_cycles(130);
        check("cont_done_per_130", 32'(st_done[0] - s_done[0]), 32'd2);
        check("cont_ch1_busy", 32'(st_busy[1] - s_busy[1]), 32'd0);

        // Reload 2/2 ten clocks into HIGH.
        wait_level(0, 0, 1'b1, "reload_rise");
        run_cycles(9);
        set_cfg(0, 2, 2, 1'b0);
        count_level(0, 0, 1'b1, n);
        check("reload_old_high_rest", 32'(n), 32'd35);
        count_level(0, 0, 1'b0, n);
        check("reload_old_low", 32'(n), 32'd20);
        count_level(0, 0, 1'b1, n);
        check("reload_new_high", 32'(n), 32'd10);
        count_level(0, 0, 1'b0, n);
        check("reload_new_low", 32'(n), 32'd10);

        // One-shot 3/1 on ch1, with a second trigger while busy.
        set_cfg(1, 3, 1, 1'b1);
        run_cycles(2);
        s_hi = st_hi; s_busy = st_busy; s_done = st_done;
        bus.trigger[1] = 1'b1;
        run_cycles(1);
        wait_level(1, 1, 1'b1, "oneshot_start");
        run_cycles(3);
        bus.trigger[1] = 1'b1;
        run_cycles(1);
        run_cycles(60);
        check("oneshot_high", 32'(st_hi[1] - s_hi[1]), 32'd15);
        check("oneshot_busy", 32'(st_busy[1] - s_busy[1]), 32'd20);
        check("oneshot_done", 32'(st_done[1] - s_done[1]), 32'd1);
        check("oneshot_idle", 32'(bus.busy[1]), 32'd0);

        // Maximum counts on ch1.
        bus.en[1] = 1'b1;
        set_cfg(1, 15, 15, 1'b0);
        measure(1, 75, 75, "max");

        // Edge duties on ch0.
        set_cfg(0, 0, 3, 1'b0);
        run_cycles(60);
        s_hi = st_hi; s_done = st_done;
        run_cycles(150);
        check("m0_high", 32'(st_hi[0] - s_hi[0]), 32'd0);
        check("m0_done", 32'(st_done[0] - s_done[0]), 32'd10);
        set_cfg(0, 5, 0, 1'b0);
        run_cycles(60);
        s_hi = st_hi; s_done = st_done;
        run_cycles(150);
        check("n0_high", 32'(st_hi[0] - s_hi[0]), 32'd150);
        check("n0_done", 32'(st_done[0] - s_done[0]), 32'd6);
        set_cfg(0, 0, 0, 1'b0);
        run_cycles(60);
        s_busy = st_busy; s_done = st_done;
        run_cycles(100);
        check("zero_busy", 32'(st_busy[0] - s_busy[0]), 32'd0);
        check("zero_done", 32'(st_done[0] - s_done[0]), 32'd0);

        // Drop enable ten clocks into HIGH: the period completes, then idle.
        set_cfg(0, 9, 4, 1'b0);
        wait_level(0, 0, 1'b1, "endrop_rise");
        run_cycles(9);
        bus.en[0] = 1'b0;
        count_level(0, 0, 1'b1, n);
        check("endrop_high_rest", 32'(n), 32'd36);
        count_level(1, 0, 1'b1, n);
        check("endrop_low", 32'(n), 32'd20);
        s_busy = st_busy;
        run_cycles(100);
        check("endrop_idle", 32'(st_busy[0] - s_busy[0]), 32'd0);

        // Reset mid-HIGH clears outputs at once and loses the shadow.
        bus.en[0] = 1'b1;
        set_cfg(0, 9, 4, 1'b0);
        wait_level(0, 0, 1'b1, "rst_rise");
        run_cycles(5);
        reset = 1'b1;
        #1;
        model_clear();
        check("async_rst_wave", 32'(bus.wave), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_done", 32'(bus.period_done), 32'd0);
        run_cycles(3);
        reset = 1'b0;
        s_busy = st_busy;
        run_cycles(100);
        check("post_rst_idle0", 32'(st_busy[0] - s_busy[0]), 32'd0);
        check("post_rst_idle1", 32'(st_busy[1] - s_busy[1]), 32'd0);
        set_cfg(0, 3, 2, 1'b0);
        measure(0, 15, 10, "post_rst");

        // Random traffic on both channels.
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < N_CH; k++) begin
                if ($urandom_range(0, 39) == 0) begin
                    bus.m_in[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 15));
                    bus.n_in[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 15));
                    bus.oneshot[k] = 1'($urandom_range(0, 1));
                    bus.load[k]    = 1'b1;
                end
                if ($urandom_range(0, 19) == 0) bus.trigger[k] = 1'b1;
                if ($urandom_range(0, 99) == 0) bus.en[k] = ~bus.en[k];
            end
            run_cycles(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
